// File: rtl/lsu_bus_ctrl.sv
// ============================================================================
// Module   : lsu_bus_ctrl
// Function : Load/store unit between the core datapath and a word-addressed
//            valid/ready data bus, with bus wait-time timeout.
// Revision : 1.0
// ============================================================================
`default_nettype none

module lsu_bus_ctrl #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        misaligned,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [7:0] c_cnt_last = 8'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [2:0]  r_funct3;
  logic [1:0]  r_off;
  logic [31:0] r_rdata;
  logic        r_bus_err;
  logic        r_bus_we;
  logic [31:0] r_bus_addr;
  logic [31:0] r_bus_wdata;
  logic [3:0]  r_bus_be;

  logic        w_pending;
  logic        w_legal_f3;
  logic        w_aligned;
  logic        w_legal;
  logic        w_start;
  logic [31:0] w_st_wdata;
  logic [3:0]  w_st_be;
  logic [7:0]  w_ld_byte;
  logic [15:0] w_ld_half;
  logic [31:0] w_ld_data;

  assign w_pending = mem_read | mem_write;

  // A simultaneous read and write request is treated as a write.
  always_comb begin
    w_legal_f3 = 1'b0;
    if (mem_write) w_legal_f3 = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
    else           w_legal_f3 = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
  end

  always_comb begin
    w_aligned = 1'b1;
    case (funct3[1:0])
      2'b01:   w_aligned = ~addr[0];
      2'b10:   w_aligned = (addr[1:0] == 2'b00);
      default: w_aligned = 1'b1;
    endcase
  end

  assign w_legal    = w_legal_f3 & w_aligned;
  assign w_start    = (r_state == S_IDLE) & w_pending & w_legal;
  assign misaligned = (r_state == S_IDLE) & w_pending & ~w_legal;
  assign stall      = w_start | (r_state == S_REQ);
  assign bus_req    = (r_state == S_REQ);
  assign bus_err    = r_bus_err;
  assign rdata      = misaligned ? 32'd0 : r_rdata;
  assign bus_we     = r_bus_we;
  assign bus_addr   = r_bus_addr;
  assign bus_wdata  = r_bus_wdata;
  assign bus_be     = r_bus_be;

  always_comb begin
    w_st_wdata = wdata;
    w_st_be    = 4'b1111;
    case (funct3)
      3'b000: begin
        w_st_wdata = {4{wdata[7:0]}};
        w_st_be    = 4'b0001 << addr[1:0];
      end
      3'b001: begin
        w_st_wdata = {2{wdata[15:0]}};
        w_st_be    = addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        w_st_wdata = wdata;
        w_st_be    = 4'b1111;
      end
    endcase
  end

  // Lane selection uses the offset captured at request time, not the live addr.
  assign w_ld_byte = bus_rdata[{r_off, 3'b000} +: 8];
  assign w_ld_half = r_off[1] ? bus_rdata[31:16] : bus_rdata[15:0];

  always_comb begin
    w_ld_data = bus_rdata;
    case (r_funct3)
      3'b000:  w_ld_data = {{24{w_ld_byte[7]}}, w_ld_byte};
      3'b100:  w_ld_data = {24'd0, w_ld_byte};
      3'b001:  w_ld_data = {{16{w_ld_half[15]}}, w_ld_half};
      3'b101:  w_ld_data = {16'd0, w_ld_half};
      default: w_ld_data = bus_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= 8'd0;
      r_funct3    <= 3'd0;
      r_off       <= 2'd0;
      r_rdata     <= 32'd0;
      r_bus_err   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= 32'd0;
      r_bus_wdata <= 32'd0;
      r_bus_be    <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_bus_err <= 1'b0;
          if (w_start) begin
            r_bus_we    <= mem_write;
            r_bus_addr  <= {addr[31:2], 2'b00};
            r_bus_wdata <= mem_write ? w_st_wdata : 32'd0;
            r_bus_be    <= mem_write ? w_st_be : 4'b1111;
            r_funct3    <= funct3;
            r_off       <= addr[1:0];
            r_cnt       <= 8'd0;
            r_state     <= S_REQ;
          end
        end
        S_REQ: begin
          if (bus_ready) begin
            r_rdata <= r_bus_we ? 32'd0 : w_ld_data;
            r_state <= S_DONE;
          end else if (r_cnt == c_cnt_last) begin
            r_bus_err <= 1'b1;
            r_rdata   <= 32'd0;
            r_state   <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_DONE: begin
          r_bus_err <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lsu_bus_ctrl.sv
// ============================================================================
// Module   : tb_lsu_bus_ctrl
// Function : Self-checking bench for lsu_bus_ctrl against a behavioural model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_lsu_bus_ctrl;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, rdata;
  logic        stall, misaligned, bus_err, bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;
  logic        bus_ready;

  int n_chk  = 0;
  int n_fail = 0;

  lsu_bus_ctrl #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .addr(addr), .wdata(wdata), .rdata(rdata),
    .stall(stall), .misaligned(misaligned), .bus_err(bus_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_ready(bus_ready),
    .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference rules expressed as size/offset arithmetic.
  function automatic bit legal(input bit we, input logic [2:0] f3, input logic [31:0] a);
    int size = int'(f3[1:0]);
    int off  = int'(a[1:0]);
    if (we && f3 > 3'd2) return 1'b0;
    if (!we && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 1'b0;
    return (off % (1 << size)) == 0;
  endfunction

  function automatic logic [3:0] exp_be(input bit we, input logic [2:0] f3, input int off);
    if (!we) return 4'hF;
    if (f3 == 3'd0) return 4'(1 << off);
    if (f3 == 3'd1) return 4'(3 << ((off / 2) * 2));
    return 4'hF;
  endfunction

  function automatic logic [31:0] exp_wd(input logic [2:0] f3, input logic [31:0] wd);
    if (f3 == 3'd0) return {24'd0, wd[7:0]} * 32'h01010101;
    if (f3 == 3'd1) return {16'd0, wd[15:0]} * 32'h00010001;
    return wd;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input int off, input logic [31:0] w);
    logic [31:0] v;
    case (f3)
      3'd0, 3'd4: begin
        v = (w >> (8 * off)) & 32'hFF;
        if (f3 == 3'd0 && v >= 32'd128) v = v - 32'd256;
      end
      3'd1, 3'd5: begin
        v = (w >> (16 * (off / 2))) & 32'hFFFF;
        if (f3 == 3'd1 && v >= 32'h8000) v = v - 32'h10000;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  // One access from IDLE; waits >= TIMEOUT means bus_ready never comes.
  task automatic access(input bit rd, input bit wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int waits, input logic [31:0] rword);
    bit we  = wr;
    bit ok  = legal(we, f3, a);
    bit tmo = (waits >= TIMEOUT);
    int stalls = 0;
    int nreq;
    mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd; bus_ready = 1'b0;
    @(negedge clk);
    chk("misaligned", 32'(misaligned), 32'(!ok));
    chk("idle_bus_req", 32'(bus_req), 32'd0);
    if (!ok) begin
      chk("illegal_stall", 32'(stall), 32'd0);
      chk("illegal_rdata", rdata, 32'd0);
      @(posedge clk); #1;
      mem_read = 1'b0; mem_write = 1'b0;
      @(negedge clk);
      chk("illegal_no_req", 32'(bus_req), 32'd0);
      @(posedge clk); #1;
      return;
    end
    stalls += int'(stall);
    @(posedge clk); #1;
    nreq = tmo ? TIMEOUT : waits + 1;
    for (int k = 0; k < nreq; k++) begin
      bus_ready = !tmo && (k == waits);
      bus_rdata = bus_ready ? rword : $urandom;
      @(negedge clk);
      chk("req_bus_req", 32'(bus_req), 32'd1);
      chk("req_bus_we", 32'(bus_we), 32'(we));
      chk("req_bus_addr", bus_addr, {a[31:2], 2'b00});
      chk("req_bus_be", 32'(bus_be), 32'(exp_be(we, f3, int'(a[1:0]))));
      if (we) chk("req_bus_wdata", bus_wdata, exp_wd(f3, wd));
      stalls += int'(stall);
      @(posedge clk); #1;
    end
    bus_ready = 1'($urandom_range(0, 1));
    bus_rdata = $urandom;
    mem_read = 1'b0; mem_write = 1'b0;
    @(negedge clk);
    chk("done_bus_req", 32'(bus_req), 32'd0);
    chk("done_stall", 32'(stall), 32'd0);
    chk("done_bus_err", 32'(bus_err), 32'(tmo));
    chk("done_rdata", rdata, (tmo || we) ? 32'd0 : exp_load(f3, int'(a[1:0]), rword));
    chk("stall_cycles", 32'(stalls), 32'(nreq + 1));
    @(posedge clk); #1;
    bus_ready = 1'b0;
    @(negedge clk);
    chk("after_bus_err", 32'(bus_err), 32'd0);
    chk("after_bus_req", 32'(bus_req), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'd0;
    addr = 32'd0; wdata = 32'd0; bus_ready = 1'b0; bus_rdata = 32'd0;
    #1;
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_bus_be", 32'(bus_be), 32'd0);
    chk("rst_bus_we", 32'(bus_we), 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_bus_wdata", bus_wdata, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    access(1'b0, 1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 0, 32'd0);
    access(1'b1, 1'b0, 3'b000, 32'h0000_2001, 32'd0, 0, 32'h1234_80FF);
    access(1'b1, 1'b0, 3'b100, 32'h0000_2001, 32'd0, 0, 32'h1234_80FF);
    access(1'b1, 1'b0, 3'b101, 32'h0000_2002, 32'd0, 0, 32'h1234_80FF);
    access(1'b1, 1'b0, 3'b001, 32'h0000_2001, 32'd0, 0, 32'd0);
    access(1'b1, 1'b0, 3'b010, 32'h0000_2002, 32'd0, 0, 32'd0);
    access(1'b1, 1'b0, 3'b011, 32'h0000_2000, 32'd0, 0, 32'd0);
    access(1'b1, 1'b0, 3'b010, 32'h0000_3000, 32'd0, 4, 32'hDEAD_BEEF);
    access(1'b0, 1'b1, 3'b010, 32'h0000_4000, 32'h1111_2222, 100, 32'd0);
    access(1'b1, 1'b1, 3'b001, 32'h0000_5006, 32'hCAFE_BABE, 1, 32'h0);

    // Reset during the second REQ cycle of a load.
    mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h0000_6000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0; mem_read = 1'b0;
    #1;
    chk("midrst_bus_req", 32'(bus_req), 32'd0);
    chk("midrst_stall", 32'(stall), 32'd0);
    chk("midrst_bus_be", 32'(bus_be), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    access(1'b1, 1'b0, 3'b010, 32'h0000_7000, 32'd0, 0, 32'h0BAD_F00D);

    for (int i = 0; i < 40; i++) begin
      int sel = $urandom_range(0, 2);
      access(sel != 1, sel != 0, 3'($urandom_range(0, 7)), $urandom, $urandom,
             $urandom_range(0, 3), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/lsu_bus_ctrl.md
Name: lsu_bus_ctrl

Overview:
- Load/store unit sitting between the core datapath (ALUResult, WriteData, ReadData) and a word-addressed data-memory bus with a valid/ready handshake.
- Converts funct3-qualified byte/halfword/word accesses into byte-enabled word transfers, and sign- or zero-extends load data.
- Stalls the core while a transfer is outstanding and bounds bus wait time with a timeout.

Parameters:
- TIMEOUT_CYCLES, 15: maximum REQ-state cycles waiting for bus_ready before the access is aborted with an error (1..255).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- mem_read  input  1  load request from control for the current instruction
- mem_write  input  1  store request from control for the current instruction
- funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr  input  32  byte address (ALUResult)
- wdata  input  32  store data (WriteData)
- rdata  output  32  formatted load data to the datapath (ReadData)
- stall  output  1  freeze PC/register-file commit while high
- misaligned  output  1  illegal alignment or funct3 on the current access
- bus_err  output  1  timeout abort, valid in the DONE cycle
- bus_req  output  1  bus transfer valid
- bus_we  output  1  1 = write
- bus_addr  output  32  word-aligned address, addr[31:2] concatenated with 2'b00
- bus_wdata  output  32  lane-replicated store data
- bus_be  output  4  byte enables
- bus_ready  input  1  bus accepts/completes the transfer this cycle
- bus_rdata  input  32  read word, valid when bus_ready is high

Behaviour:
- Reset: asynchronous and active-low. State goes to IDLE; bus_req, bus_we, bus_addr, bus_wdata, bus_be, the rdata register, bus_err and the timeout counter all go to 0. A reset asserted mid-transfer drops bus_req immediately.
- Access pending = mem_read | mem_write. If both are high, the access is a write.
- Legal accesses:
  - LB/LBU/SB: any address.
  - LH/LHU/SH: addr[0] = 0.
  - LW/SW: addr[1:0] = 0.
  - Stores with funct3 other than 000/001/010, and loads with funct3 011/110/111, are illegal.
- misaligned: combinational; high only in IDLE when an access is pending and illegal. In that case no bus transfer starts, stall = 0 and rdata = 0.
- FSM states: IDLE, REQ, DONE.
  - IDLE -> REQ: on a legal pending access. Register bus_we, bus_addr, bus_wdata, bus_be; clear the counter. stall = 1 in this cycle.
  - REQ: bus_req = 1 and stall = 1. All bus_* outputs are held stable until the handshake completes.
  - REQ, bus_ready = 1: register the formatted load data (0 for writes) into rdata; go to DONE.
  - REQ, bus_ready = 0: increment the counter. When the counter reaches TIMEOUT_CYCLES-1 without ready, set bus_err, rdata = 0, go to DONE.
  - DONE: bus_req = 0, stall = 0, rdata and bus_err valid. The core commits this cycle. Always returns to IDLE, ignoring mem_read/mem_write in this cycle. bus_err clears on leaving DONE.
- Minimum access latency is 3 cycles (IDLE, REQ, DONE), i.e. 2 stall cycles. Each wait-state cycle adds 1.
- Store formatting:
  - SB: bus_wdata = {4{wdata[7:0]}}, bus_be = 4'b0001 << addr[1:0].
  - SH: bus_wdata = {2{wdata[15:0]}}, bus_be = addr[1] ? 4'b1100 : 4'b0011.
  - SW: bus_wdata = wdata, bus_be = 4'b1111.
- Loads: bus_be = 4'b1111. The lane is selected by the registered addr[1:0].
  - LB/LH: sign-extend the selected lane.
  - LBU/LHU: zero-extend the selected lane.
  - LW: pass the word through.
- bus_ready seen outside REQ is ignored.

Test Plan:
- SB addr=0x00001003, wdata=0x000000A5, bus_ready high in the first REQ cycle -> bus_addr=0x00001000, bus_be=1000, bus_wdata=0xA5A5A5A5, bus_we=1; stall high for 2 cycles, low in DONE.
- LB addr=0x00002001, bus_rdata=0x123480FF -> rdata=0xFFFFFF80 in DONE. Repeat with LBU -> 0x00000080. LHU addr=0x00002002 -> 0x00001234.
- LH addr=0x00002001 -> misaligned=1, stall=0, no bus_req, rdata=0. LW addr=0x00002002 -> misaligned=1. funct3=011 load -> misaligned=1.
- LW addr=0x00003000, bus_ready held low 4 REQ cycles then high with bus_rdata=0xDEADBEEF -> bus outputs stable throughout, stall high 6 cycles, rdata=0xDEADBEEF.
- SW with bus_ready never asserted, TIMEOUT_CYCLES=15 -> exactly 15 REQ cycles, then DONE with bus_err=1, rdata=0, stall=0, back to IDLE.
- rst_n pulled low in the 2nd REQ cycle -> bus_req, stall, bus_be immediately 0. After release, state is IDLE and a new LW completes normally.
